mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency memory between the instruction-fetch port (read-only) and the data port (load/store) of the MIPS core.
- Sequences each access through issue, wait and response.
- Gates read data to zero outside the response cycle, so the datapath sees data only when it is valid.
- Sits between the IF/MEM pipeline stages and the memory macro; the pipeline stalls while a port's ready is low.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from the mem_re cycle to the cycle mem_rdata is valid; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- i_req  in  1  instruction read request; held until i_ready.
- i_addr  in  ADDR_W  instruction address.
- i_ready  out  1  one-cycle completion pulse for the instruction port.
- i_rdata  out  DATA_W  instruction data; equals mem_rdata when i_ready=1, otherwise 0.
- d_req  in  1  data request; held until d_ready.
- d_we  in  1  1=store, 0=load; valid with d_req.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ready  out  1  one-cycle completion pulse for the data port.
- d_rdata  out  DATA_W  load data; equals mem_rdata when d_ready=1 on a load, otherwise 0.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. A 2-bit state register plus a latency counter.
- IDLE:
  - No request: stay in IDLE.
  - One request pending: grant it.
  - Both pending: grant the port that did not receive the last grant.
  - last_grant resets to I, so the data port wins the first tie.
  - On grant: latch port id, address, we (forced to 0 for the I port) and wdata; update last_grant; go to ISSUE.
- ISSUE:
  - mem_addr = latched address; mem_re = ~we; mem_we = we; mem_wdata = latched wdata.
  - Next state: store -> RESP. Load with MEM_LAT==1 -> RESP. Otherwise load cnt = MEM_LAT-1 and go to WAIT.
- WAIT: mem_re=0, mem_we=0. If cnt==1 go to RESP, else decrement cnt.
- RESP:
  - Pulse the granted port's ready for exactly one cycle.
  - For a load, drive that port's rdata combinationally from mem_rdata.
  - Next state: IDLE.
- Latency, with request accepted in IDLE at cycle T:
  - Load: mem_re at T+1, ready/rdata at T+1+MEM_LAT.
  - Store: mem_we at T+1, ready at T+2.
  - The earliest next grant is the cycle after RESP.
- Data gating:
  - i_rdata and d_rdata are 0 in every cycle except their own port's RESP cycle on a read.
  - The non-granted port's ready and rdata stay 0.
  - mem_addr and mem_wdata hold their latched values when idle.
  - mem_re and mem_we are never high together, and each is high for only one cycle per access.
- Request dropped mid-access: the access still completes and ready still pulses; no abort is possible.
- Request still high in the cycle after ready: treated as a new request.
- Reset:
  - While rst_n=0 at a clock edge: state becomes IDLE, cnt and latches clear, last_grant becomes I.
  - All outputs are 0 from that edge on; in-flight accesses are discarded and no ready is produced for them.

Test Plan:
- Reset with both req high, rst_n=0 for 2 cycles -> mem_re, mem_we, i_ready, d_ready, busy, i_rdata and d_rdata all 0; first tie after rst_n=1 grants D.
- MEM_LAT=2, i_req with i_addr=0x00400000, mem_rdata=0x8C080004 at the ISSUE+2 cycle -> mem_re at T+1, i_ready and i_rdata=0x8C080004 at T+3; i_rdata=0 at T+2 and T+4.
- Store d_we=1, d_addr=0x10010000, d_wdata=0xDEADBEEF -> mem_we=1 with that addr/data at T+1, mem_re=0, d_ready at T+2, d_rdata=0.
- Both ports requesting continuously -> grant order D, I, D, I; each ready is one cycle wide; 4 reads complete within 4*(MEM_LAT+2)=16 cycles.
- Load issued, rst_n=0 asserted during WAIT -> next edge goes to IDLE, no d_ready pulse, busy=0.
- MEM_LAT=1 build, d_req load -> mem_re at T+1, d_ready at T+2, and WAIT is never entered.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port arbiter in front of a single-port fixed-latency memory
//
// Purpose:
//   Shares one single-port memory between the instruction-fetch port
//   (read-only) and the data port (load/store). Each access runs
//   IDLE -> ISSUE -> (WAIT) -> RESP. Ties alternate between the ports.
//   Read data reaches a port only in that port's response cycle.
//
// Ports:
//   clk, rst_n                 clock (rising edge), synchronous active-low reset
//   i_req, i_addr              instruction read request / address (held until i_ready)
//   i_ready, i_rdata           instruction completion pulse / gated read data
//   d_req, d_we, d_addr,
//   d_wdata                    data request, 1=store, address, store data
//   d_ready, d_rdata           data completion pulse / gated load data
//   mem_addr, mem_wdata        memory address / write data (hold latched values)
//   mem_re, mem_we             one-cycle memory read / write strobes
//   mem_rdata                  memory read data, valid MEM_LAT cycles after mem_re
//   busy                       high whenever the arbiter is not idle

module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // The counter only has to hold MEM_LAT-1.
  localparam int CNT_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam bit LAT_ONE = (MEM_LAT == 1);

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_port;
  logic              r_last_grant;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_mem_re;
  logic              r_mem_we;
  logic              r_i_ready;
  logic              r_d_ready;
  logic              r_busy;

  // D wins when it is alone, or on a tie when I had the previous grant.
  logic w_grant_d;
  logic w_any_req;
  logic w_new_we;

  assign w_any_req = i_req | d_req;
  assign w_grant_d = d_req & (~i_req | (r_last_grant == PORT_I));
  assign w_new_we  = w_grant_d & d_we;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_port       <= PORT_I;
      r_last_grant <= PORT_I;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mem_re     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_i_ready    <= 1'b0;
      r_d_ready    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      // Strobes and ready pulses are single-cycle unless set below.
      r_mem_re  <= 1'b0;
      r_mem_we  <= 1'b0;
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_port       <= w_grant_d;
            r_last_grant <= w_grant_d;
            r_addr       <= w_grant_d ? d_addr : i_addr;
            r_we         <= w_new_we;
            r_wdata      <= w_grant_d ? d_wdata : '0;
            r_mem_re     <= ~w_new_we;
            r_mem_we     <= w_new_we;
            r_busy       <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_we || LAT_ONE) begin
            r_i_ready <= (r_port == PORT_I);
            r_d_ready <= (r_port == PORT_D);
            r_state   <= S_RESP;
          end else begin
            r_cnt   <= CNT_W'(MEM_LAT - 1);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == CNT_W'(1)) begin
            r_i_ready <= (r_port == PORT_I);
            r_d_ready <= (r_port == PORT_D);
            r_state   <= S_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_re    = r_mem_re;
  assign mem_we    = r_mem_we;
  assign i_ready   = r_i_ready;
  assign d_ready   = r_d_ready;
  assign busy      = r_busy;

  // Memory data passes through only during the owning port's load response.
  assign i_rdata = (r_i_ready && !r_we) ? mem_rdata : '0;
  assign d_rdata = (r_d_ready && !r_we) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
//
// Purpose:
//   Directed vector table, continuous-contention and MEM_LAT=1 sequences,
//   then randomized traffic checked against a transaction-level model.
//
// Ports: none (top-level bench).

module tb_mem_port_arbiter;

  localparam int LAT_A = 2;
  localparam logic [31:0] IA = 32'h0040_0000;
  localparam logic [31:0] DA = 32'h1001_0000;
  localparam logic [31:0] DW = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: MEM_LAT=2
  logic        a_rst_n, a_ireq, a_dreq, a_dwe, a_iready, a_dready, a_re, a_we, a_busy;
  logic [31:0] a_iaddr, a_daddr, a_dwdata, a_irdata, a_drdata, a_maddr, a_mwdata, a_mrd;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT_A)) u_a (
    .clk(clk), .rst_n(a_rst_n),
    .i_req(a_ireq), .i_addr(a_iaddr), .i_ready(a_iready), .i_rdata(a_irdata),
    .d_req(a_dreq), .d_we(a_dwe), .d_addr(a_daddr), .d_wdata(a_dwdata),
    .d_ready(a_dready), .d_rdata(a_drdata),
    .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_re(a_re), .mem_we(a_we),
    .mem_rdata(a_mrd), .busy(a_busy)
  );

  // Instance B: MEM_LAT=1
  logic        b_rst_n, b_ireq, b_dreq, b_dwe, b_iready, b_dready, b_re, b_we, b_busy;
  logic [31:0] b_iaddr, b_daddr, b_dwdata, b_irdata, b_drdata, b_maddr, b_mwdata, b_mrd;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_b (
    .clk(clk), .rst_n(b_rst_n),
    .i_req(b_ireq), .i_addr(b_iaddr), .i_ready(b_iready), .i_rdata(b_irdata),
    .d_req(b_dreq), .d_we(b_dwe), .d_addr(b_daddr), .d_wdata(b_dwdata),
    .d_ready(b_dready), .d_rdata(b_drdata),
    .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_re(b_re), .mem_we(b_we),
    .mem_rdata(b_mrd), .busy(b_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        ireq;
    logic        dreq;
    logic        dwe;
    logic [31:0] mrd;
    logic        re;
    logic        we;
    logic        ir;
    logic        dr;
    logic        bz;
    logic [31:0] ird;
    logic [31:0] drd;
    logic [31:0] maddr;
  } vec_t;

  vec_t tbl [18];

  // Transaction-level reference model: an access is a grant cycle plus
  // offsets; strobe at +1, response at +2 (store) or +1+MEM_LAT (load).
  int          cyc;
  int          m_g;
  bit          m_active, m_port, m_we, m_last;
  logic [31:0] m_addr, m_wdata;

  task automatic model_reset();
    m_active = 0; m_port = 0; m_we = 0; m_last = 0;
    m_addr = '0; m_wdata = '0;
  endtask

  task automatic model_step();
    int k, rk;
    bit e_resp, e_re, e_we;
    logic [31:0] e_ird, e_drd;
    k  = cyc - m_g;
    rk = m_we ? 2 : 1 + LAT_A;
    e_re   = m_active && k == 1 && !m_we;
    e_we   = m_active && k == 1 && m_we;
    e_resp = m_active && k == rk;
    e_ird  = (e_resp && !m_port && !m_we) ? a_mrd : 32'h0;
    e_drd  = (e_resp && m_port && !m_we) ? a_mrd : 32'h0;
    chk("rnd_busy", {31'b0, a_busy}, {31'b0, m_active});
    chk("rnd_mem_re", {31'b0, a_re}, {31'b0, e_re});
    chk("rnd_mem_we", {31'b0, a_we}, {31'b0, e_we});
    chk("rnd_re_we_excl", {31'b0, a_re & a_we}, 32'h0);
    chk("rnd_i_ready", {31'b0, a_iready}, {31'b0, e_resp && !m_port});
    chk("rnd_d_ready", {31'b0, a_dready}, {31'b0, e_resp && m_port});
    chk("rnd_i_rdata", a_irdata, e_ird);
    chk("rnd_d_rdata", a_drdata, e_drd);
    chk("rnd_mem_addr", a_maddr, m_addr);
    if (e_we) chk("rnd_mem_wdata", a_mwdata, m_wdata);
    if (!a_rst_n) begin
      model_reset();
    end else if (m_active) begin
      if (k == rk) m_active = 0;
    end else if (a_ireq || a_dreq) begin
      m_port   = a_dreq && (!a_ireq || m_last == 1'b0);
      m_last   = m_port;
      m_we     = m_port && a_dwe;
      m_addr   = m_port ? a_daddr : a_iaddr;
      m_wdata  = m_port ? a_dwdata : 32'h0;
      m_g      = cyc;
      m_active = 1;
    end
    cyc++;
  endtask

  initial begin
    int          n_done, dbl;
    logic        prev_i, prev_d;
    logic [1:0]  order [4];
    logic [31:0] b_data;

    //       rst ireq dreq dwe mrd           re we ir dr bz ird           drd           maddr
    tbl[0]  = '{0, 1, 1, 0, 32'h0,         0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0};
    tbl[1]  = '{0, 1, 1, 0, 32'h0,         0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0};
    tbl[2]  = '{1, 1, 1, 0, 32'h0,         0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0};
    tbl[3]  = '{1, 1, 1, 0, 32'h0,         1, 0, 0, 0, 1, 32'h0,        32'h0,        DA};
    tbl[4]  = '{1, 1, 1, 0, 32'h0,         0, 0, 0, 0, 1, 32'h0,        32'h0,        DA};
    tbl[5]  = '{1, 1, 1, 0, 32'h1111_2222, 0, 0, 0, 1, 1, 32'h0,        32'h1111_2222, DA};
    tbl[6]  = '{1, 1, 1, 0, 32'h1111_2222, 0, 0, 0, 0, 0, 32'h0,        32'h0,        DA};
    tbl[7]  = '{1, 1, 0, 0, 32'h0,         1, 0, 0, 0, 1, 32'h0,        32'h0,        IA};
    tbl[8]  = '{1, 1, 0, 0, 32'h8C08_0004, 0, 0, 0, 0, 1, 32'h0,        32'h0,        IA};
    tbl[9]  = '{1, 1, 0, 0, 32'h8C08_0004, 0, 0, 1, 0, 1, 32'h8C08_0004, 32'h0,       IA};
    tbl[10] = '{1, 0, 1, 1, 32'h8C08_0004, 0, 0, 0, 0, 0, 32'h0,        32'h0,        IA};
    tbl[11] = '{1, 0, 1, 1, 32'h8C08_0004, 0, 1, 0, 0, 1, 32'h0,        32'h0,        DA};
    tbl[12] = '{1, 0, 1, 1, 32'h8C08_0004, 0, 0, 0, 1, 1, 32'h0,        32'h0,        DA};
    tbl[13] = '{1, 0, 1, 0, 32'h0,         0, 0, 0, 0, 0, 32'h0,        32'h0,        DA};
    tbl[14] = '{1, 0, 1, 0, 32'h0,         1, 0, 0, 0, 1, 32'h0,        32'h0,        DA};
    tbl[15] = '{0, 0, 1, 0, 32'h0,         0, 0, 0, 0, 1, 32'h0,        32'h0,        DA};
    tbl[16] = '{1, 0, 0, 0, 32'h5A5A_5A5A, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0};
    tbl[17] = '{1, 0, 0, 0, 32'h5A5A_5A5A, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0};

    a_iaddr = IA; a_daddr = DA; a_dwdata = DW;
    b_rst_n = 0; b_ireq = 0; b_dreq = 0; b_dwe = 0;
    b_iaddr = 32'h0; b_daddr = 32'h2000_0040; b_dwdata = 32'h0; b_mrd = 32'h0;

    // Directed vector table on the MEM_LAT=2 instance.
    for (int r = 0; r < 18; r++) begin
      if (r != 0) begin
        @(posedge clk); #1;
      end
      a_rst_n = tbl[r].rst; a_ireq = tbl[r].ireq; a_dreq = tbl[r].dreq;
      a_dwe = tbl[r].dwe; a_mrd = tbl[r].mrd;
      @(negedge clk);
      chk($sformatf("tbl%0d_mem_re", r), {31'b0, a_re}, {31'b0, tbl[r].re});
      chk($sformatf("tbl%0d_mem_we", r), {31'b0, a_we}, {31'b0, tbl[r].we});
      chk($sformatf("tbl%0d_i_ready", r), {31'b0, a_iready}, {31'b0, tbl[r].ir});
      chk($sformatf("tbl%0d_d_ready", r), {31'b0, a_dready}, {31'b0, tbl[r].dr});
      chk($sformatf("tbl%0d_busy", r), {31'b0, a_busy}, {31'b0, tbl[r].bz});
      chk($sformatf("tbl%0d_i_rdata", r), a_irdata, tbl[r].ird);
      chk($sformatf("tbl%0d_d_rdata", r), a_drdata, tbl[r].drd);
      chk($sformatf("tbl%0d_mem_addr", r), a_maddr, tbl[r].maddr);
      if (tbl[r].we) chk($sformatf("tbl%0d_mem_wdata", r), a_mwdata, DW);
    end

    // Continuous contention: expect D, I, D, I, each ready one cycle wide.
    @(posedge clk); #1;
    a_rst_n = 0; a_ireq = 1; a_dreq = 1; a_dwe = 0;
    @(posedge clk); #1;
    a_rst_n = 1;
    n_done = 0; dbl = 0; prev_i = 0; prev_d = 0;
    for (int c = 0; c < 16; c++) begin
      a_mrd = $urandom;
      @(negedge clk);
      if ((a_iready && prev_i) || (a_dready && prev_d) || (a_iready && a_dready)) dbl++;
      if ((a_iready || a_dready) && n_done < 4) begin
        order[n_done] = {a_dready, a_iready};
        n_done++;
      end
      prev_i = a_iready; prev_d = a_dready;
      @(posedge clk); #1;
    end
    chk("cont_done_count", n_done, 4);
    chk("cont_wide_pulses", dbl, 0);
    if (n_done == 4) begin
      chk("cont_order0", {30'b0, order[0]}, 32'h2);
      chk("cont_order1", {30'b0, order[1]}, 32'h1);
      chk("cont_order2", {30'b0, order[2]}, 32'h2);
      chk("cont_order3", {30'b0, order[3]}, 32'h1);
    end

    // MEM_LAT=1 instance: load response follows the read strobe directly.
    b_rst_n = 0;
    @(posedge clk); #1;
    b_rst_n = 1; b_dreq = 1; b_dwe = 0;
    b_data = 32'hCAFE_0123;
    @(negedge clk);
    chk("l1_T_busy", {31'b0, b_busy}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("l1_T1_mem_re", {31'b0, b_re}, 32'h1);
    chk("l1_T1_d_ready", {31'b0, b_dready}, 32'h0);
    chk("l1_T1_mem_addr", b_maddr, 32'h2000_0040);
    @(posedge clk); #1;
    b_mrd = b_data;
    @(negedge clk);
    chk("l1_T2_d_ready", {31'b0, b_dready}, 32'h1);
    chk("l1_T2_d_rdata", b_drdata, b_data);
    chk("l1_T2_mem_re", {31'b0, b_re}, 32'h0);
    chk("l1_T2_i_ready", {31'b0, b_iready}, 32'h0);
    @(posedge clk); #1;
    b_dreq = 0;
    @(negedge clk);
    chk("l1_T3_busy", {31'b0, b_busy}, 32'h0);
    chk("l1_T3_d_rdata", b_drdata, 32'h0);

    // Randomized traffic against the reference model.
    @(posedge clk); #1;
    a_rst_n = 0;
    @(posedge clk); #1;
    model_reset();
    cyc = 0; m_g = 0;
    for (int n = 0; n < 3000; n++) begin
      a_rst_n  = ($urandom_range(0, 79) != 0);
      a_ireq   = ($urandom_range(0, 2) != 0);
      a_dreq   = ($urandom_range(0, 2) != 0);
      a_dwe    = $urandom_range(0, 1);
      a_iaddr  = $urandom;
      a_daddr  = $urandom;
      a_dwdata = $urandom;
      a_mrd    = $urandom;
      @(negedge clk);
      model_step();
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
